l1_l2_port_arbiter: RTL and testbench
=====================================

Name: l1_l2_port_arbiter

Overview:
- Shares the single L2 line port between the L1 instruction-cache refill path (read-only) and the L1 data-cache controller (refill reads and dirty writebacks).
- Arbitrates round-robin and latches the winner's request.
- Drives the L2 req/ready/data_valid handshake and routes the line response back to the owner.
- Allows one outstanding L2 transaction at a time.

Parameters:
- LINE_SIZE, 64, cache line size in bytes. L2 data width is LINE_SIZE*8.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ic_req  in  1  I-cache request; held high until ic_accept.
- ic_addr  in  ADDR_WIDTH  I-cache line address.
- ic_accept  out  1  one-cycle pulse: I-cache request latched.
- ic_resp_valid  out  1  one-cycle pulse: resp_data holds the I-cache line.
- dc_req  in  1  D-cache request; held high until dc_accept.
- dc_we  in  1  1 = writeback, 0 = refill read.
- dc_addr  in  ADDR_WIDTH  D-cache line address.
- dc_wdata  in  LINE_SIZE*8  writeback line.
- dc_accept  out  1  one-cycle pulse: D-cache request latched.
- dc_resp_valid  out  1  one-cycle pulse: D-cache transaction complete; resp_data valid for reads.
- resp_data  out  LINE_SIZE*8  last l2_read_data captured.
- l2_req  out  1  request to L2.
- l2_we  out  1  write enable to L2.
- l2_addr  out  ADDR_WIDTH  line-aligned L2 address.
- l2_write_data  out  LINE_SIZE*8  writeback data.
- l2_read_data  in  LINE_SIZE*8  L2 read line.
- l2_data_valid  in  1  L2 completion pulse.
- l2_ready  in  1  L2 can accept a request.
- busy  out  1  high whenever state != IDLE.
- grant_owner  out  1  0 = I-cache, 1 = D-cache; current or last owner.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including resp_data, l2_addr, l2_write_data and protocol_err.
  - last_grant resets to 0 (I-cache), so the first tie goes to the D-cache.
  - Reset asserted mid-transaction abandons the transaction: no resp pulse, no further l2_req.
- State IDLE:
  - Only dc_req high: D-cache wins. Only ic_req high: I-cache wins.
  - Both high: the winner is the requester not equal to last_grant.
  - At the edge, latch the winner's addr with bits [log2(LINE_SIZE)-1:0] forced to 0, its we (0 for I-cache) and its wdata (0 for I-cache).
  - Set grant_owner and last_grant to the winner and go to ISSUE.
  - In the first ISSUE cycle, the winner's *_accept is 1 for exactly one cycle.
- State ISSUE:
  - l2_req = 1, with l2_we, l2_addr and l2_write_data driven from the latched values and stable throughout.
  - When l2_req && l2_ready is seen at an edge, go to WAIT; l2_req = 0 from the next cycle.
  - Otherwise stay in ISSUE indefinitely.
- State WAIT:
  - l2_req = 0.
  - On l2_data_valid: capture l2_read_data into resp_data only if the transaction was a read, pulse the owner's *_resp_valid for one cycle, and go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> accept and l2_req in cycle 1.
  - With l2_ready high and L2 completing N cycles after the handshake, resp_valid rises N+1 cycles after the handshake edge.
  - Minimum request-to-response: 3 cycles.
- Re-arbitration:
  - No new grant until back in IDLE; requesters hold req while waiting.
  - After a response the block re-enters IDLE and can grant on the next edge, so back-to-back transactions are separated by at least one IDLE cycle.
- Requester protocol: dropping req before accept is legal, and the request is simply not granted.
- protocol_err:
  - Set by l2_data_valid in IDLE or ISSUE.
  - Set by dc_req and ic_req deasserting and reasserting is not checked.
  - Cleared only by rst.
  - A spurious l2_data_valid is otherwise ignored: no resp pulse, no state change.
- ic_resp_valid and dc_resp_valid are never high in the same cycle. ic_accept and dc_accept are never high in the same cycle.

Test Plan:
- Single DC read: dc_req=1, dc_we=0, dc_addr=0x0000_1234, l2_ready=1, l2_data_valid 2 cycles after handshake with data=0xA5..A5.
  - Expect dc_accept in cycle 1, l2_addr=0x0000_1200, l2_we=0, dc_resp_valid with resp_data=0xA5..A5, ic_resp_valid stays 0.
- Tie after reset: ic_req and dc_req high together.
  - Expect D-cache granted first, then I-cache; grant_owner sequence 1 then 0.
- Writeback with L2 stall: dc_we=1, dc_wdata pattern, l2_ready=0 for 5 cycles.
  - Expect l2_req held high for 6 cycles with stable addr/data, dc_resp_valid after completion, resp_data unchanged.
- Continuous contention: both requesters re-request immediately for 4 transactions.
  - Expect strict alternation DC, IC, DC, IC.
- Spurious completion: l2_data_valid pulsed in IDLE.
  - Expect protocol_err=1 sticky, no resp pulses.
- Reset mid-WAIT: rst during WAIT, then l2_data_valid.
  - Expect all outputs 0, state IDLE, no resp pulse; protocol_err set by the late l2_data_valid.

Source files
------------

// File: rtl/l1_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : l1_l2_port_arbiter
// Brief   : Round-robin arbiter sharing one L2 line port between the L1
//           I-cache refill path and the L1 D-cache (refill + writeback).
// Revision: 1.0 - initial release
// ============================================================================
module l1_l2_port_arbiter #(
    parameter int LINE_SIZE  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ic_req,
    input  logic [ADDR_WIDTH-1:0]   ic_addr,
    output logic                    ic_accept,
    output logic                    ic_resp_valid,
    input  logic                    dc_req,
    input  logic                    dc_we,
    input  logic [ADDR_WIDTH-1:0]   dc_addr,
    input  logic [LINE_SIZE*8-1:0]  dc_wdata,
    output logic                    dc_accept,
    output logic                    dc_resp_valid,
    output logic [LINE_SIZE*8-1:0]  resp_data,
    output logic                    l2_req,
    output logic                    l2_we,
    output logic [ADDR_WIDTH-1:0]   l2_addr,
    output logic [LINE_SIZE*8-1:0]  l2_write_data,
    input  logic [LINE_SIZE*8-1:0]  l2_read_data,
    input  logic                    l2_data_valid,
    input  logic                    l2_ready,
    output logic                    busy,
    output logic                    grant_owner,
    output logic                    protocol_err
);

    localparam int                    c_OFFSET_BITS = $clog2(LINE_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MASK   = {ADDR_WIDTH{1'b1}} << c_OFFSET_BITS;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   w_grant;
    logic                   w_pick_dc;
    logic                   w_complete;
    logic                   w_err_set;

    logic                   r_ic_accept;
    logic                   r_dc_accept;
    logic                   r_ic_resp;
    logic                   r_dc_resp;
    logic                   r_owner;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LINE_SIZE*8-1:0] r_wdata;
    logic [LINE_SIZE*8-1:0] r_resp_data;
    logic                   r_err;

    // r_owner doubles as last_grant: a tie goes to whoever did not win last.
    assign w_pick_dc  = dc_req && (!ic_req || !r_owner);
    assign w_grant    = (r_state == c_S_IDLE) && (ic_req || dc_req);
    assign w_complete = (r_state == c_S_WAIT) && l2_data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_err_set = l2_data_valid;
                if (ic_req || dc_req) begin
                    w_state_next = c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                w_err_set = l2_data_valid;
                if (l2_ready) begin
                    w_state_next = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (l2_data_valid) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ic_accept <= 1'b0;
            r_dc_accept <= 1'b0;
            r_ic_resp   <= 1'b0;
            r_dc_resp   <= 1'b0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_ic_accept <= w_grant && !w_pick_dc;
            r_dc_accept <= w_grant && w_pick_dc;
            r_ic_resp   <= w_complete && !r_owner;
            r_dc_resp   <= w_complete && r_owner;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_grant) begin
                r_owner <= w_pick_dc;
                if (w_pick_dc) begin
                    r_we    <= dc_we;
                    r_addr  <= dc_addr & c_ADDR_MASK;
                    r_wdata <= dc_wdata;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= ic_addr & c_ADDR_MASK;
                    r_wdata <= '0;
                end
            end
            // Writebacks complete without touching the last read line.
            if (w_complete && !r_we) begin
                r_resp_data <= l2_read_data;
            end
        end
    end

    assign ic_accept     = r_ic_accept;
    assign dc_accept     = r_dc_accept;
    assign ic_resp_valid = r_ic_resp;
    assign dc_resp_valid = r_dc_resp;
    assign resp_data     = r_resp_data;
    assign l2_req        = (r_state == c_S_ISSUE);
    assign l2_we         = r_we;
    assign l2_addr       = r_addr;
    assign l2_write_data = r_wdata;
    assign busy          = (r_state != c_S_IDLE);
    assign grant_owner   = r_owner;
    assign protocol_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_l1_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_l1_l2_port_arbiter
// Brief   : Directed, table-driven self-checking bench for l1_l2_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_l1_l2_port_arbiter;

    localparam int c_LS = 64;
    localparam int c_AW = 32;
    localparam int c_DW = c_LS * 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ic_req = 1'b0;
    logic [c_AW-1:0] ic_addr = 32'h0000_4567;
    logic            ic_accept;
    logic            ic_resp_valid;
    logic            dc_req = 1'b0;
    logic            dc_we = 1'b0;
    logic [c_AW-1:0] dc_addr = 32'h0000_1234;
    logic [c_DW-1:0] dc_wdata = '0;
    logic            dc_accept;
    logic            dc_resp_valid;
    logic [c_DW-1:0] resp_data;
    logic            l2_req;
    logic            l2_we;
    logic [c_AW-1:0] l2_addr;
    logic [c_DW-1:0] l2_write_data;
    logic [c_DW-1:0] l2_read_data = '0;
    logic            l2_data_valid = 1'b0;
    logic            l2_ready = 1'b0;
    logic            busy;
    logic            grant_owner;
    logic            protocol_err;

    int checks = 0;
    int errors = 0;

    l1_l2_port_arbiter #(.LINE_SIZE(c_LS), .ADDR_WIDTH(c_AW)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_accept(ic_accept), .ic_resp_valid(ic_resp_valid),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_accept(dc_accept), .dc_resp_valid(dc_resp_valid), .resp_data(resp_data),
        .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_write_data(l2_write_data),
        .l2_read_data(l2_read_data), .l2_data_valid(l2_data_valid), .l2_ready(l2_ready),
        .busy(busy), .grant_owner(grant_owner), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // {ic_acc, dc_acc, ic_rv, dc_rv, l2_req, l2_we, busy, owner, perr}
    function automatic logic [8:0] flags();
        return {ic_accept, dc_accept, ic_resp_valid, dc_resp_valid,
                l2_req, l2_we, busy, grant_owner, protocol_err};
    endfunction

    task automatic check(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs are applied for one full cycle; outputs are sampled just after the edge.
    task automatic step(input logic r, input logic icr, input logic dcr, input logic rdy,
                        input logic dv, input logic [7:0] rd);
        @(negedge clk);
        rst           = r;
        ic_req        = icr;
        dc_req        = dcr;
        l2_ready      = rdy;
        l2_data_valid = dv;
        l2_read_data  = {c_LS{rd}};
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       rst;
        logic       icr;
        logic       dcr;
        logic       rdy;
        logic       dv;
        logic [7:0] rd;
        logic [8:0] flg;
        logic [31:0] addr;
        logic [7:0] resp;
    } vec_t;

    vec_t vt [16];

    initial begin
        logic [c_DW-1:0] wb_pat;
        logic [c_DW-1:0] resp_before;
        logic            exp_dc;

        // Single DC read, then tie after reset, then I-cache stall and a spurious completion.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'b000000000, 32'h0000_0000, 8'h00};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 9'b010010110, 32'h0000_1200, 8'h00};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 9'b000000110, 32'h0000_1200, 8'h00};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'b000000110, 32'h0000_1200, 8'h00};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 9'b000100010, 32'h0000_1200, 8'hA5};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'b000000010, 32'h0000_1200, 8'hA5};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'b000000000, 32'h0000_0000, 8'h00};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 9'b010010110, 32'h0000_1200, 8'h00};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 9'b000000110, 32'h0000_1200, 8'h00};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 9'b000100010, 32'h0000_1200, 8'h3C};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'b100010100, 32'h0000_4540, 8'h3C};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'b000010100, 32'h0000_4540, 8'h3C};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'b000000100, 32'h0000_4540, 8'h3C};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 9'b001000000, 32'h0000_4540, 8'h5A};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 9'b000000001, 32'h0000_4540, 8'h5A};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'b000000001, 32'h0000_4540, 8'h5A};

        for (int i = 0; i < 16; i++) begin
            step(vt[i].rst, vt[i].icr, vt[i].dcr, vt[i].rdy, vt[i].dv, vt[i].rd);
            check($sformatf("vec%0d_flags_addr", i), c_DW'({flags(), l2_addr}),
                  c_DW'({vt[i].flg, vt[i].addr}));
            check($sformatf("vec%0d_resp_data", i), resp_data, {c_LS{vt[i].resp}});
        end

        // Writeback with five stall cycles: l2_req high for six cycles, stable payload.
        wb_pat   = {8{64'h0123_4567_89AB_CDEF}};
        dc_addr  = 32'h0000_8FFF;
        dc_we    = 1'b1;
        dc_wdata = wb_pat;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wb_grant", c_DW'({flags(), l2_addr}), c_DW'({9'b010011110, 32'h0000_8FC0}));
        check("wb_wdata_first", l2_write_data, wb_pat);
        dc_wdata = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            check($sformatf("wb_stall%0d", i), c_DW'({flags(), l2_addr}) ^ l2_write_data,
                  c_DW'({9'b000011110, 32'h0000_8FC0}) ^ wb_pat);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("wb_handshake", c_DW'(flags()), c_DW'(9'b000001110));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        check("wb_resp", c_DW'(flags()), c_DW'(9'b000101010));
        check("wb_resp_data_kept", resp_data, '0);
        dc_we = 1'b0;

        // Continuous contention: both hold req, grants must alternate DC, IC, DC, IC.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int t = 0; t < 4; t++) begin
            exp_dc = (t % 2 == 0);
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            check($sformatf("rr%0d_grant", t), c_DW'({ic_accept, dc_accept, grant_owner}),
                  c_DW'({!exp_dc, exp_dc, exp_dc}));
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            resp_before = {c_LS{8'(8'h10 + t)}};
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'(8'h10 + t));
            check($sformatf("rr%0d_resp", t), c_DW'({ic_resp_valid, dc_resp_valid, busy}),
                  c_DW'({!exp_dc, exp_dc, 1'b0}));
            check($sformatf("rr%0d_data", t), resp_data, resp_before);
        end

        // Reset mid-WAIT, then a late completion that must only raise protocol_err.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("rw_in_wait", c_DW'(flags()), c_DW'(9'b000000110));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rw_reset_outputs", c_DW'({flags(), l2_addr}) | resp_data | l2_write_data, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
        check("rw_late_dv", c_DW'({flags(), l2_addr}) | resp_data, c_DW'(9'b000000001) << 32);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rw_after", c_DW'(flags()), c_DW'(9'b000000001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
